dmem_responder: RTL

Data-memory responder for the pipelined MIPS core. It services load/store requests from the CPU's MEM stage over a req/ready handshake and inserts a programmable number of wait states, so the hazard unit's stall path can be exercised against a realistic slow memory. It holds word-addressed RAM and flags misaligned or out-of-range accesses.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory responder: the FSM state encoding,
// the bytes per RAM word, the largest supported wait-state count, and the
// width of the wait counter.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int unsigned DMEM_WORD_BYTES  = 4;
  localparam int unsigned DMEM_MAX_LATENCY = 15;
  localparam int unsigned DMEM_CNT_W       = 4;

endpackage

// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder for the pipelined MIPS core. It accepts one load or
// store over a req/ready handshake, waits LATENCY cycles, performs the access
// on a word-addressed RAM, and then pulses ready for one cycle. Misaligned or
// out-of-range addresses are rejected: no store happens, rdata is unchanged,
// and err is raised together with ready.
//
// Parameters
//   RAM_SIZE  number of 32-bit words (power of two, 4..1024)
//   LATENCY   wait states between acceptance and response (0..15)
// Ports
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   req    access request, sampled only while idle
//   we     1 = store, 0 = load
//   addr   byte address
//   wdata  store data
//   ready  one-cycle completion pulse (registered)
//   rdata  last successful load data (registered)
//   err    access rejected, valid with ready (registered)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_SIZE = 64,
  parameter int unsigned LATENCY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned IDX_W = $clog2(RAM_SIZE);
  localparam logic [31:0] ADDR_LIMIT = 32'(DMEM_WORD_BYTES * RAM_SIZE);
  // Out-of-range LATENCY values saturate at the largest count the counter holds.
  localparam logic [DMEM_CNT_W-1:0] LAT_CNT =
    (LATENCY > DMEM_MAX_LATENCY) ? DMEM_CNT_W'(DMEM_MAX_LATENCY) : DMEM_CNT_W'(LATENCY);

  dmem_state_t           state_q, state_d;
  logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [31:0]           mem_q [RAM_SIZE];

  logic                  op_go;
  logic                  op_we;
  logic [31:0]           op_addr;
  logic [31:0]           op_wdata;
  logic                  op_err;
  logic [IDX_W-1:0]      op_idx;
  logic                  mem_we;

  // Next-state logic. op_go marks the edge that enters RESP, where the memory
  // access is carried out. With zero wait states that edge is the accepting
  // one, so the access uses the live request rather than the capture registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    op_go    = 1'b0;
    op_we    = we_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          if (LAT_CNT == '0) begin
            state_d  = RESP;
            op_go    = 1'b1;
            op_we    = we;
            op_addr  = addr;
            op_wdata = wdata;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_CNT;
          end
        end
      end
      WAIT: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        if (cnt_q <= DMEM_CNT_W'(1)) begin
          state_d = RESP;
          op_go   = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Access checks and the response registers. rdata only moves on a
  // successful load so it holds across stores and rejected accesses.
  always_comb begin
    op_idx  = op_addr[IDX_W+1:2];
    op_err  = (op_addr[1:0] != 2'b00) || (op_addr >= ADDR_LIMIT);
    ready_d = op_go;
    err_d   = op_go & op_err;
    rdata_d = rdata_q;
    if (op_go && !op_err && !op_we) begin
      rdata_d = mem_q[op_idx];
    end
    // The RAM has no reset, so writes are gated while reset is held to keep a
    // zero-latency request from storing during reset.
    mem_we = op_go & op_we & ~op_err & reset;
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[op_idx] <= op_wdata;
    end
  end

  assign ready = ready_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule
